// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default data width, legal queue depth range and
// the canonical fetch-queue entry layout.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned DEPTH_MIN    = 2;
  localparam int unsigned DEPTH_MAX    = 16;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue storage: entries allocated in request order, filled in response
// order, popped in program order. Pointers carry one extra wrap bit.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_alloc,
  input  logic [XLEN-1:0]         i_alloc_pc,
  input  logic                    i_fill,
  input  logic [XLEN-1:0]         i_fill_data,
  input  logic                    i_pop,
  output logic                    o_head_valid,
  output logic [XLEN-1:0]         o_head_pc,
  output logic [XLEN-1:0]         o_head_instr,
  output logic [$clog2(DEPTH):0]  o_used,
  output logic [$clog2(DEPTH):0]  o_pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]   r_alloc_ptr;
  logic [PW-1:0]   r_fill_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [DEPTH-1:0] r_filled;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_instr [DEPTH];

  logic [AW-1:0]   w_alloc_idx;
  logic [AW-1:0]   w_fill_idx;
  logic [AW-1:0]   w_rd_idx;

  always_comb begin
    w_alloc_idx  = r_alloc_ptr[AW-1:0];
    w_fill_idx   = r_fill_ptr[AW-1:0];
    w_rd_idx     = r_rd_ptr[AW-1:0];
    o_head_valid = r_filled[w_rd_idx];
    o_head_pc    = r_pc[w_rd_idx];
    o_head_instr = r_instr[w_rd_idx];
    o_used       = r_alloc_ptr - r_rd_ptr;
    o_pending    = r_alloc_ptr - r_fill_ptr;
  end

  // Fill only targets allocated-but-unfilled slots and pop only filled ones,
  // so same-cycle fill and pop never touch the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_filled    <= '0;
    end else if (i_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_filled    <= '0;
    end else begin
      if (i_alloc) begin
        r_alloc_ptr <= r_alloc_ptr + PW'(1);
      end
      if (i_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + PW'(1);
      end
      if (i_pop) begin
        r_filled[w_rd_idx] <= 1'b0;
        r_rd_ptr           <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_alloc) begin
      r_pc[w_alloc_idx] <= i_alloc_pc;
    end
    if (i_fill) begin
      r_instr[w_fill_idx] <= i_fill_data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: credit-based request issue, in-order response
// capture, redirect flush with discard of stale in-flight responses.
// Optional perf counters when FETCH_PERF_EN is defined.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_stall,
  input  logic            redirect,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [15:0]     perf_flushes
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  if ((DEPTH < DEPTH_MIN) || (DEPTH > DEPTH_MAX) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("if_fetch_unit: DEPTH must be a power of 2 within the supported range");
  end

  logic [CW-1:0] w_used;
  logic [CW-1:0] w_pending;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_discard_flush;
  logic [CW:0]   w_committed;
  logic          w_credit;
  logic          w_fire;
  logic          w_rsp_owned;
  logic          w_rsp_drop;
  logic          w_rsp_fill;
  logic          w_pop;
  logic          w_spurious;

  // Slots still owed a response (queued or to be discarded) count against credit.
  always_comb begin
    w_committed     = {1'b0, w_used} + {1'b0, r_discard};
    w_credit        = w_committed < DEPTH_C;
    imem_req_valid  = !rst && !redirect && w_credit;
    imem_req_addr   = pc_in;
    w_fire          = imem_req_valid && imem_req_ready;
    pc_stall        = !w_fire;
    w_rsp_owned     = (r_discard != '0) || (w_pending != '0);
    w_spurious      = imem_rsp_valid && !w_rsp_owned;
    w_rsp_drop      = imem_rsp_valid && (r_discard != '0);
    w_rsp_fill      = imem_rsp_valid && (r_discard == '0) && (w_pending != '0) && !redirect;
    w_pop           = dec_valid && dec_ready && !redirect;
    w_discard_flush = w_pending + r_discard - CW'(imem_rsp_valid && w_rsp_owned);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard <= '0;
    end else if (redirect) begin
      r_discard <= w_discard_flush;
    end else if (w_rsp_drop) begin
      r_discard <= r_discard - CW'(1);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (redirect),
    .i_alloc      (w_fire),
    .i_alloc_pc   (pc_in),
    .i_fill       (w_rsp_fill),
    .i_fill_data  (imem_rsp_data),
    .i_pop        (w_pop),
    .o_head_valid (dec_valid),
    .o_head_pc    (dec_pc),
    .o_head_instr (dec_instr),
    .o_used       (w_used),
    .o_pending    (w_pending)
  );

  a_rsp_without_request: assert property (@(posedge clk) disable iff (rst) !w_spurious);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (pc_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect) begin
        r_perf_flush <= r_perf_flush + 16'd1;
      end
    end
  end

  always_comb begin
    perf_stall_cycles = r_perf_stall;
    perf_flushes      = r_perf_flush;
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, decode backpressure, redirects
// with in-flight discard, memory stall and mid-transfer reset.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        redirect;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  logic [31:0] redir_pc;
  logic        mem_en;
  logic [31:0] mq [$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  if_fetch_unit #(.DEPTH(4), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_stall       (pc_stall),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: jump on redirect, advance only on an accepted request.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_in <= 32'h0;
    else if (redirect) pc_in <= redir_pc;
    else if (!pc_stall) pc_in <= pc_in + 32'd4;
  end

  // In-order memory; instruction word is the inverted address. mem_en=0 holds responses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
      if (mem_en && (mq.size() > 0)) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= ~mq.pop_front();
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected summary before 200000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    fetch_entry_t e;
    e.pc     = pc;
    e.instr  = instr;
    e.filled = 1'b1;
    chk1({tag, "_valid"}, dec_valid, e.filled);
    chk({tag, "_pc"}, dec_pc, e.pc);
    chk({tag, "_instr"}, dec_instr, e.instr);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redir_pc = 32'h0;
    imem_req_ready = 1'b1; dec_ready = 1'b1; mem_en = 1'b1;
    tick();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_pc_stall", pc_stall, 1'b1);
    chk1("rst_dec_valid", dec_valid, 1'b0);

    // Steady stream
    do_reset();
    chk1("stream_req_valid", imem_req_valid, 1'b1);
    chk("stream_req_addr", imem_req_addr, 32'h0);
    chk1("stream_pc_stall0", pc_stall, 1'b0);
    tick(); tick();
    chk_dec("stream0", 32'h0, 32'hFFFF_FFFF);
    tick();
    chk_dec("stream1", 32'h4, 32'hFFFF_FFFB);
    chk1("stream_pc_stall1", pc_stall, 1'b0);
    tick();
    chk_dec("stream2", 32'h8, 32'hFFFF_FFF7);
    chk1("stream_pc_stall2", pc_stall, 1'b0);

    // Decode stall fills the queue, then drains without loss
    dec_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk1("full_req_valid", imem_req_valid, 1'b0);
    chk1("full_pc_stall", pc_stall, 1'b1);
    chk_dec("full_head", 32'h0, 32'hFFFF_FFFF);
    tick();
    chk_dec("hold_head", 32'h0, 32'hFFFF_FFFF);
    chk("hold_addr", imem_req_addr, 32'h10);
    chk1("hold_req_valid", imem_req_valid, 1'b0);
    dec_ready = 1'b1;
    #1;
    tick();
    chk_dec("resume0", 32'h4, 32'hFFFF_FFFB);
    chk1("resume_req_valid", imem_req_valid, 1'b1);
    tick();
    chk_dec("resume1", 32'h8, 32'hFFFF_FFF7);
    tick();
    chk_dec("resume2", 32'hC, 32'hFFFF_FFF3);
    tick();
    chk_dec("resume3", 32'h10, 32'hFFFF_FFEF);

    // Redirect with two requests outstanding
    mem_en = 1'b0;
    do_reset();
    tick(); tick();
    redirect = 1'b1; redir_pc = 32'h100; mem_en = 1'b1;
    #1;
    chk1("redir2_req_valid", imem_req_valid, 1'b0);
    chk1("redir2_pc_stall", pc_stall, 1'b1);
    tick();
    redirect = 1'b0;
    #1;
    chk1("redir2_new_req", imem_req_valid, 1'b1);
    chk("redir2_new_addr", imem_req_addr, 32'h100);
    chk1("redir2_drop0", dec_valid, 1'b0);
    tick();
    chk1("redir2_drop1", dec_valid, 1'b0);
    tick();
    chk1("redir2_wait", dec_valid, 1'b0);
    tick();
    chk_dec("redir2_first", 32'h100, 32'hFFFF_FEFF);
    tick();
    chk_dec("redir2_second", 32'h104, 32'hFFFF_FEFB);

    // Redirect in the same cycle as a response, three outstanding
    mem_en = 1'b0;
    do_reset();
    tick(); tick();
    mem_en = 1'b1;
    tick();
    redirect = 1'b1; redir_pc = 32'h200;
    #1;
    chk1("redir3_req_valid", imem_req_valid, 1'b0);
    tick();
    redirect = 1'b0;
    #1;
    chk1("redir3_no_stale", dec_valid, 1'b0);
    chk1("redir3_new_req", imem_req_valid, 1'b1);
    chk("redir3_new_addr", imem_req_addr, 32'h200);
    tick();
    chk1("redir3_drop", dec_valid, 1'b0);
    tick();
    chk1("redir3_wait", dec_valid, 1'b0);
    tick();
    chk_dec("redir3_first", 32'h200, 32'hFFFF_FDFF);

    // Memory not ready for five cycles
    imem_req_ready = 1'b0; mem_en = 1'b1; dec_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redir_pc = 32'h40;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("memstall%0d_pc_stall", i), pc_stall, 1'b1);
      chk($sformatf("memstall%0d_addr", i), imem_req_addr, 32'h40);
      if (i < 4) tick();
    end
    imem_req_ready = 1'b1;
    #1;
    chk1("memgo_pc_stall", pc_stall, 1'b0);
    tick();
    chk("memgo_next_addr", imem_req_addr, 32'h44);
    tick();
    chk_dec("memgo_first", 32'h40, 32'hFFFF_FFBF);

    // Reset with three entries filled
    dec_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk_dec("prerst_head", 32'h0, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    chk1("midrst_dec_valid", dec_valid, 1'b0);
    chk1("midrst_pc_stall", pc_stall, 1'b1);
    chk1("midrst_req_valid", imem_req_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("midrst_perf_stall", perf_stall_cycles, 32'h0);
    chk("midrst_perf_flush", {16'h0, perf_flushes}, 32'h0);
`endif
    dec_ready = 1'b1;
    do_reset();
    tick(); tick();
    chk_dec("postrst_head", 32'h0, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
